// File: rtl/ser_arbiter_if.sv
// ser_arbiter_if -- bundle of requester and serializer signals for ser_arbiter.
//   req_data_i  N_REQ*DATA_W  per-requester word, requester k at [k*DATA_W +: DATA_W]
//   req_mod_i   N_REQ*MOD_W   per-requester bit count, packed the same way
//   req_val_i   N_REQ         per-requester valid, held stable until accepted
//   req_ready_o N_REQ         accept strobe, at most one bit high
//   ser_data_o  DATA_W        word to serializer
//   ser_mod_o   MOD_W         bit count to serializer (0 = full width)
//   ser_val_o   1             one-cycle launch strobe
//   ser_busy_i  1             serializer busy
//   grant_id_o  clog2(N_REQ)  requester owning the serializer
//   busy_o      1             transfer in progress
//   err_o       1             one-cycle busy-timeout pulse
// modport master: the arbiter side. modport slave: requesters + serializer side.
interface ser_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int MOD_W  = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ*MOD_W-1:0]  req_mod_i;
  logic [N_REQ-1:0]        req_val_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic [DATA_W-1:0]       ser_data_o;
  logic [MOD_W-1:0]        ser_mod_o;
  logic                    ser_val_o;
  logic                    ser_busy_i;
  logic [ID_W-1:0]         grant_id_o;
  logic                    busy_o;
  logic                    err_o;

  modport master (
    input  req_data_i, req_mod_i, req_val_i, ser_busy_i,
    output req_ready_o, ser_data_o, ser_mod_o, ser_val_o, grant_id_o, busy_o, err_o
  );

  modport slave (
    output req_data_i, req_mod_i, req_val_i, ser_busy_i,
    input  req_ready_o, ser_data_o, ser_mod_o, ser_val_o, grant_id_o, busy_o, err_o
  );
endinterface

// File: rtl/ser_arbiter.sv
// ser_arbiter -- round-robin arbiter feeding one serializer from N_REQ requesters.
// An idle arbiter accepts the first valid requester at or after the round-robin
// pointer, launches its word for one cycle, then waits up to BUSY_TO cycles for
// the serializer to go busy and for busy to fall again. Timeout pulses err_o.
// Ports:
//   clk_i   single clock, rising edge
//   srst_i  synchronous active-high reset
//   bus     ser_arbiter_if.master (requester handshake and serializer link)
module ser_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int MOD_W   = 4,
  parameter int BUSY_TO = 3
) (
  input  logic          clk_i,
  input  logic          srst_i,
  ser_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] data_q;
  logic [MOD_W-1:0]  mod_q;
  logic              ser_val_q;
  logic              busy_q;
  logic              err_q;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [DATA_W-1:0] win_data;
  logic [MOD_W-1:0]  win_mod;
  logic [ID_W-1:0]   next_ptr;
  logic              accept;

  // Round-robin search: first valid index at or after rr_ptr_q, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ID_W'((32'(rr_ptr_q) + i) % 32'(N_REQ));
      if (!win_found && bus.req_val_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_data = bus.req_data_i[win_idx*DATA_W +: DATA_W];
    win_mod  = bus.req_mod_i[win_idx*MOD_W +: MOD_W];
  end

  assign next_ptr = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);

  // Ready is combinational so the handshake completes in the arbitration cycle.
  assign accept          = (state_q == IDLE) && win_found && !srst_i;
  assign bus.req_ready_o = accept ? (N_REQ'(1) << win_idx) : '0;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      mod_q     <= '0;
      ser_val_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ser_val_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            data_q    <= win_data;
            mod_q     <= win_mod;
            grant_q   <= win_idx;
            ser_val_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.ser_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
            // BUSY_TO cycles in WAIT_BUSY without busy: give up on this transfer.
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            data_q   <= '0;
            mod_q    <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.ser_busy_i) begin
            busy_q   <= 1'b0;
            data_q   <= '0;
            mod_q    <= '0;
            rr_ptr_q <= next_ptr;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // data_q/mod_q are cleared on every return to IDLE, so they read zero there.
  assign bus.ser_data_o = data_q;
  assign bus.ser_mod_o  = mod_q;
  assign bus.ser_val_o  = ser_val_q;
  assign bus.grant_id_o = grant_q;
  assign bus.busy_o     = busy_q;
  assign bus.err_o      = err_q;
endmodule

// File: doc/ser_arbiter.md
SER_ARBITER -- requirements
Module: ser_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_W, default 16, parallel word width.
REQ-003 Parameter MOD_W, default 4, bit-count field width (0 = full DATA_W bits).
REQ-004 Parameter BUSY_TO, default 3, cycles allowed between launch and serializer busy.
REQ-005 clk_i  in  1  single clock; all logic on rising edge.
REQ-006 srst_i  in  1  synchronous, active-high reset.
REQ-007 req_data_i  in  N_REQ*DATA_W  per-requester word; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 req_mod_i  in  N_REQ*MOD_W  per-requester bit count, packed the same way.
REQ-009 req_val_i  in  N_REQ  per-requester valid; held with data stable until accepted.
REQ-010 req_ready_o  out  N_REQ  accept strobe; at most one bit high per cycle.
REQ-011 ser_data_o  out  DATA_W  word to serializer.
REQ-012 ser_mod_o  out  MOD_W  bit count to serializer.
REQ-013 ser_val_o  out  1  one-cycle launch strobe to serializer.
REQ-014 ser_busy_i  in  1  serializer busy.
REQ-015 grant_id_o  out  $clog2(N_REQ)  index of requester owning the serializer; valid while busy_o high.
REQ-016 busy_o  out  1  high from acceptance until the transfer completes or times out.
REQ-017 err_o  out  1  one-cycle pulse on busy timeout.

Function
REQ-018 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if any req_val_i bit high, winner = first valid index at or after rr_ptr, searching upward with wrap-around modulo N_REQ.
REQ-020 IDLE with a winner: req_ready_o[winner] high combinationally in the same cycle; winner's data and mod latched; grant_id_o <= winner; next state LAUNCH.
REQ-021 req_ready_o all zero in every state other than IDLE.
REQ-022 LAUNCH: ser_val_o = 1 for exactly this one cycle; ser_data_o/ser_mod_o = latched values; next state WAIT_BUSY.
REQ-023 ser_data_o/ser_mod_o hold latched values from LAUNCH until return to IDLE; zero in IDLE.
REQ-024 WAIT_BUSY: ser_busy_i high -> WAIT_DONE; otherwise a counter increments; when it reaches BUSY_TO without busy -> err_o pulse, next state IDLE.
REQ-025 WAIT_DONE: stay while ser_busy_i high; ser_busy_i low -> IDLE.
REQ-026 On leaving WAIT_DONE or a timeout exit: rr_ptr <= (grant_id_o + 1) mod N_REQ.
REQ-027 busy_o = 1 in LAUNCH, WAIT_BUSY, WAIT_DONE; 0 in IDLE.
REQ-028 Launch latency: handshake in cycle T -> ser_val_o in cycle T+1.
REQ-029 Minimum spacing between successive launches: one IDLE cycle after busy falls.
REQ-030 req_mod_i passes unmodified; value 0 is forwarded as 0 (serializer interprets it as full width).
REQ-031 req_val_i changes outside IDLE are ignored; no request is lost; it is served on a later IDLE.
REQ-032 A single persistent requester is re-served every round; with all requesters valid, grants rotate 0,1,2,...,N_REQ-1,0.

Reset
REQ-033 srst_i high at any clock edge: state <= IDLE, rr_ptr <= 0, timeout counter <= 0, latched data/mod <= 0, grant_id_o <= 0.
REQ-034 During and after reset: req_ready_o, ser_val_o, busy_o, err_o = 0; ser_data_o/ser_mod_o = 0.
REQ-035 Reset mid-transfer aborts it; no ser_val_o is issued for the aborted request and rr_ptr is not advanced.

Verification
REQ-036 Single request: req_val_i=4'b0010, data 16'hA5C3, mod 4'd8 -> ready[1] same cycle; next cycle ser_val_o=1, ser_data_o=16'hA5C3, ser_mod_o=8; grant_id_o=1.
REQ-037 All four valid continuously, busy modelled as 16 cycles -> grants in order 0,1,2,3,0; one ready per handshake; no launch overlaps busy.
REQ-038 Pointer at 3, requests 4'b0101 -> winner 0 (wrap), then winner 2.
REQ-039 ser_busy_i held 0 after launch -> err_o pulses exactly BUSY_TO=3 cycles after WAIT_BUSY entry; FSM returns to IDLE; rr_ptr advances.
REQ-040 srst_i asserted while in WAIT_DONE -> next cycle all outputs 0, state IDLE, rr_ptr=0; pending request served only after reset is released.
